// File: rtl/forward_hazard_unit.sv
// Execute-stage operand forwarding and load-use hazard detection over DEPTH in-flight result slots.
// Outputs are combinational (0 cycles); stall holds EX/earlier while the slot shifter keeps advancing every cycle.
module forward_hazard_unit #(
  parameter int  DATA_WIDTH  = 32,
  parameter int  ADDR_WIDTH  = 5,
  parameter int  NUM_SRC     = 2,
  parameter int  DEPTH       = 2,
  parameter int  LAT_WIDTH   = 2,
  parameter int  FLUSH_SLOTS = 0,
  localparam int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           issue_valid,
  input  logic                           issue_we,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  input  logic [LAT_WIDTH-1:0]           issue_lat,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]  src_rs,
  input  logic [NUM_SRC-1:0]             src_used,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  rf_data,
  input  logic [DEPTH*DATA_WIDTH-1:0]    stage_data,
  input  logic                           flush,
  output logic [NUM_SRC*DATA_WIDTH-1:0]  operand,
  output logic [NUM_SRC*SEL_W-1:0]       fwd_sel,
  output logic                           stall,
  output logic [15:0]                    stall_count
);

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [ADDR_WIDTH-1:0] rd;
    logic [LAT_WIDTH-1:0]  cnt;
  } slot_t;

  slot_t              slot_q [DEPTH];
  slot_t              slot_d [DEPTH];
  logic [DEPTH-1:0]   hit    [NUM_SRC];
  logic [NUM_SRC-1:0] busy;

  // x0 is hardwired zero, so it never forwards and never stalls.
  always_comb begin
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int i = 0; i < DEPTH; i++) begin
        hit[j][i] = src_used[j] && slot_q[i].valid && slot_q[i].we &&
                    (slot_q[i].rd == src_rs[j*ADDR_WIDTH +: ADDR_WIDTH]) &&
                    (src_rs[j*ADDR_WIDTH +: ADDR_WIDTH] != '0);
      end
    end
  end

  // Scan oldest to youngest so the youngest match overrides; its readiness alone decides stall.
  always_comb begin
    operand = rf_data;
    fwd_sel = '0;
    busy    = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (hit[j][i]) begin
          fwd_sel[j*SEL_W +: SEL_W]          = SEL_W'(i + 1);
          operand[j*DATA_WIDTH +: DATA_WIDTH] = stage_data[i*DATA_WIDTH +: DATA_WIDTH];
          busy[j]                             = (slot_q[i].cnt != '0);
        end
      end
    end
  end

  assign stall = |busy;

  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      slot_d[i]     = slot_q[i-1];
      slot_d[i].cnt = (slot_q[i-1].cnt != '0) ? slot_q[i-1].cnt - LAT_WIDTH'(1) : '0;
      if (flush && (i < FLUSH_SLOTS)) begin
        slot_d[i].valid = 1'b0;
      end
    end
    slot_d[0] = '0;
    if (!flush && !stall && issue_valid) begin
      slot_d[0] = '{valid: 1'b1, we: issue_we, rd: issue_rd, cnt: issue_lat};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      stall_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
      if (stall && !flush && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed checks of forward_hazard_unit in a 2-slot/2-source and a 3-slot/3-source configuration.
module tb_forward_hazard_unit;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: DEPTH=2, NUM_SRC=2
  logic          a_iv, a_we, a_flush;
  logic [AW-1:0] a_rd;
  logic [1:0]    a_lat;
  logic [2*AW-1:0] a_rs;
  logic [1:0]    a_used;
  logic [2*DW-1:0] a_rf, a_stage, a_op;
  logic [3:0]    a_sel;
  logic          a_stall;
  logic [15:0]   a_cnt;

  // Instance B: DEPTH=3, NUM_SRC=3
  logic          b_iv, b_we, b_flush;
  logic [AW-1:0] b_rd;
  logic [1:0]    b_lat;
  logic [3*AW-1:0] b_rs;
  logic [2:0]    b_used;
  logic [3*DW-1:0] b_rf, b_stage, b_op;
  logic [5:0]    b_sel;
  logic          b_stall;
  logic [15:0]   b_cnt;

  forward_hazard_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SRC(2), .DEPTH(2),
                        .LAT_WIDTH(2), .FLUSH_SLOTS(0)) u_a (
    .clk(clk), .rst_n(rst_n), .issue_valid(a_iv), .issue_we(a_we), .issue_rd(a_rd),
    .issue_lat(a_lat), .src_rs(a_rs), .src_used(a_used), .rf_data(a_rf),
    .stage_data(a_stage), .flush(a_flush), .operand(a_op), .fwd_sel(a_sel),
    .stall(a_stall), .stall_count(a_cnt));

  forward_hazard_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SRC(3), .DEPTH(3),
                        .LAT_WIDTH(2), .FLUSH_SLOTS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .issue_valid(b_iv), .issue_we(b_we), .issue_rd(b_rd),
    .issue_lat(b_lat), .src_rs(b_rs), .src_used(b_used), .rf_data(b_rf),
    .stage_data(b_stage), .flush(b_flush), .operand(b_op), .fwd_sel(b_sel),
    .stall(b_stall), .stall_count(b_cnt));

  typedef struct {
    bit          dut;
    bit          stall;
    logic [5:0]  sel;
    logic [15:0] cnt;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  event  sample_ev;

  function automatic logic [95:0] exp_op(input bit dut, input logic [5:0] sel);
    logic [95:0] r;
    logic [1:0]  s;
    logic [31:0] v;
    int          n;
    r = '0;
    n = dut ? 3 : 2;
    for (int j = 0; j < n; j++) begin
      s = sel[j*2 +: 2];
      if (dut) v = (s == 2'd0) ? b_rf[j*32 +: 32] : b_stage[(int'(s)-1)*32 +: 32];
      else     v = (s == 2'd0) ? a_rf[j*32 +: 32] : a_stage[(int'(s)-1)*32 +: 32];
      r[j*32 +: 32] = v;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input string fld, input logic [95:0] act, input logic [95:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, want %h", nm, fld, act, req);
    end
  endtask

  // Monitor: pops every pending expectation when outputs are sampled.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk or sample_ev);
      while (q.size() != 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        if (e.dut) begin
          chk(nm, "stall", {95'b0, b_stall}, {95'b0, e.stall});
          chk(nm, "fwd_sel", {90'b0, b_sel}, {90'b0, e.sel});
          chk(nm, "operand", b_op, exp_op(1'b1, e.sel));
          chk(nm, "stall_count", {80'b0, b_cnt}, {80'b0, e.cnt});
        end else begin
          chk(nm, "stall", {95'b0, a_stall}, {95'b0, e.stall});
          chk(nm, "fwd_sel", {92'b0, a_sel}, {90'b0, e.sel});
          chk(nm, "operand", {32'b0, a_op}, exp_op(1'b0, e.sel));
          chk(nm, "stall_count", {80'b0, a_cnt}, {80'b0, e.cnt});
        end
      end
    end
  end

  task automatic push(input string nm, input bit dut, input bit st, input logic [5:0] sel, input logic [15:0] cnt);
    exp_t e;
    e.dut = dut; e.stall = st; e.sel = sel; e.cnt = cnt;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic idle_all();
    a_iv = 0; a_we = 0; a_rd = '0; a_lat = '0; a_rs = '0; a_used = '0; a_flush = 0;
    b_iv = 0; b_we = 0; b_rd = '0; b_lat = '0; b_rs = '0; b_used = '0; b_flush = 0;
  endtask

  task automatic drive_a(input bit iv, input bit we, input int rd, input int lat,
                         input int rs0, input int rs1, input logic [1:0] used, input bit fl);
    a_iv = iv; a_we = we; a_rd = AW'(rd); a_lat = 2'(lat);
    a_rs = {AW'(rs1), AW'(rs0)}; a_used = used; a_flush = fl;
  endtask

  // One cycle on A: drive, queue the expected comb response, advance to just after the next edge.
  task automatic step_a(input string nm, input bit iv, input bit we, input int rd, input int lat,
                        input int rs0, input int rs1, input logic [1:0] used, input bit fl,
                        input bit st, input int s0, input int s1, input int cnt);
    drive_a(iv, we, rd, lat, rs0, rs1, used, fl);
    push(nm, 1'b0, st, {2'b00, 2'(s1), 2'(s0)}, 16'(cnt));
    @(posedge clk); #1;
  endtask

  task automatic step_b(input string nm, input bit iv, input bit we, input int rd, input int lat,
                        input int rs2, input logic [2:0] used,
                        input bit st, input int s2, input int cnt);
    b_iv = iv; b_we = we; b_rd = AW'(rd); b_lat = 2'(lat);
    b_rs = {AW'(rs2), AW'(0), AW'(0)}; b_used = used; b_flush = 1'b0;
    push(nm, 1'b1, st, {2'(s2), 4'b0000}, 16'(cnt));
    @(posedge clk); #1;
  endtask

  initial begin
    a_rf    = {32'hF1F1_F1F1, 32'hF0F0_F0F0};
    a_stage = {32'hBBBB_0001, 32'h0000_1234};
    b_rf    = {32'hE2E2_E2E2, 32'hE1E1_E1E1, 32'hE0E0_E0E0};
    b_stage = {32'hC000_0002, 32'hC000_0001, 32'hC000_0000};
    idle_all();
    rst_n = 1'b0;
    #1;
    push("reset_a", 1'b0, 1'b0, 6'd0, 16'd0);
    push("reset_b", 1'b1, 1'b0, 6'd0, 16'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    //      name            iv we rd lat rs0 rs1 used  fl  st s0 s1 cnt
    step_a("alu_issue",      1, 1, 5, 0,  0,  0, 2'b00, 0, 0, 0, 0, 0);
    step_a("alu_fwd",        0, 0, 0, 0,  5,  0, 2'b01, 0, 0, 1, 0, 0);
    step_a("ld_issue",       1, 1, 6, 1,  0,  0, 2'b00, 0, 0, 0, 0, 0);
    step_a("ld_use_stall",   1, 1, 9, 0,  0,  6, 2'b10, 0, 1, 0, 1, 0);
    step_a("ld_use_fwd",     1, 1, 9, 0,  0,  6, 2'b10, 0, 0, 0, 2, 1);
    step_a("yng_issue1",     1, 1, 7, 0,  0,  0, 2'b00, 0, 0, 0, 0, 1);
    step_a("yng_issue2",     1, 1, 7, 0,  0,  0, 2'b00, 0, 0, 0, 0, 1);
    step_a("yng_fwd",        0, 0, 0, 0,  7,  7, 2'b11, 0, 0, 1, 1, 1);
    step_a("x0_issue",       1, 1, 0, 1,  0,  0, 2'b00, 0, 0, 0, 0, 1);
    step_a("x0_src",         1, 1,10, 0,  0,  0, 2'b01, 0, 0, 0, 0, 1);
    step_a("unused_src",     0, 0, 0, 0, 10, 10, 2'b00, 0, 0, 0, 0, 1);
    step_a("flush_issue",    1, 1, 8, 1,  0,  0, 2'b00, 1, 0, 0, 0, 1);
    step_a("flush_src",      0, 0, 0, 0,  8,  0, 2'b01, 0, 0, 0, 0, 1);
    step_a("ld2_issue",      1, 1,11, 1,  0,  0, 2'b00, 0, 0, 0, 0, 1);
    step_a("stall_flush",    1, 1,12, 0, 11,  0, 2'b01, 1, 1, 1, 0, 1);
    step_a("post_flush_fwd", 0, 0, 0, 0, 11,  0, 2'b01, 0, 0, 2, 0, 1);
    step_a("rst_ld_issue",   1, 1,12, 1,  0,  0, 2'b00, 0, 0, 0, 0, 1);

    // Stall pending, then pull reset between edges.
    drive_a(0, 0, 0, 0, 12, 0, 2'b01, 0);
    push("rst_pre_stall", 1'b0, 1'b1, 6'b000001, 16'd1);
    #6;
    rst_n = 1'b0;
    #1;
    push("rst_async_a", 1'b0, 1'b0, 6'd0, 16'd0);
    -> sample_ev;
    @(posedge clk); #3;
    rst_n = 1'b1;
    idle_all();
    @(posedge clk); #1;

    //      name        iv we rd lat rs2 used   st s2 cnt
    step_b("b_issue",    1, 1,13, 2,  0, 3'b000, 0, 0, 0);
    step_b("b_stall1",   0, 0, 0, 0, 13, 3'b100, 1, 1, 0);
    step_b("b_stall2",   0, 0, 0, 0, 13, 3'b100, 1, 2, 1);
    step_b("b_fwd3",     0, 0, 0, 0, 13, 3'b100, 0, 3, 2);
    idle_all();

    step_a("far_issue",      1, 1,14, 2,  0,  0, 2'b00, 0, 0, 0, 0, 0);
    step_a("far_stall1",     0, 0, 0, 0, 14,  0, 2'b01, 0, 1, 1, 0, 0);
    step_a("far_stall2",     0, 0, 0, 0, 14,  0, 2'b01, 0, 1, 2, 0, 1);
    step_a("far_rf",         0, 0, 0, 0, 14,  0, 2'b01, 0, 0, 0, 0, 2);
    idle_all();

    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
